stack_controller: RTL and testbench

Command sequencer that drives a WIDTH-wide stack built from WIDTH parallel `shift_register` bit-slices of SIZE=DEPTH, one slice per data bit, all sharing one `mode` bus. It accepts word-level stack/ALU commands over a valid/ready handshake and translates each into one `STACK_MODE_*` mode pulse plus a per-slice `d` bit. It tracks occupancy, rejects overflow and underflow, and computes ADD/SUB results from the slice read-back. It sits between the calculator's decode logic and the bit-slice array.

---
 rtl/stack_controller_if.sv | 30 +++
 rtl/stack_controller.sv | 158 +++++++++++++++
 tb/tb_stack_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_controller_if.sv
// rtl/stack_controller_if.sv - command handshake and bit-slice bus between decode, controller and slice array
interface stack_controller_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_imm;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] second;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_imm, top, second,
    input  cmd_ready, mode, d, depth, empty, full, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm, top, second,
    output cmd_ready, mode, d, depth, empty, full, err
  );
endinterface

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - word-level stack/ALU command sequencer for a bit-sliced shift-register stack
// Optional bounds checking and sticky err: define STACK_CONTROLLER_BOUNDS_CHECK_EN.
`ifndef STACK_MODE_IDLE
`define STACK_MODE_IDLE  3'd0
`define STACK_MODE_PUSH  3'd1
`define STACK_MODE_POP   3'd2
`define STACK_MODE_SWAP  3'd3
`define STACK_MODE_ROLL2 3'd4
`define STACK_MODE_RESET 3'd7
`endif

module stack_controller #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  stack_controller_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);
`ifdef STACK_CONTROLLER_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_ADD   = 3'd5;
  localparam logic [2:0] OP_SUB   = 3'd6;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;

  logic             accept;
  logic             ok;
  logic             inc, dec, clr;
  logic [2:0]       cmd_mode;
  logic [WIDTH-1:0] cmd_d;

  assign accept = (state_q == S_IDLE) && bus.cmd_valid;

  always_comb begin
    cmd_mode = `STACK_MODE_IDLE;
    cmd_d    = '0;
    ok       = 1'b1;
    inc      = 1'b0;
    dec      = 1'b0;
    clr      = 1'b0;
    case (bus.cmd_op)
      OP_NOP: ;
      OP_PUSH: begin
        cmd_mode = `STACK_MODE_PUSH;
        cmd_d    = bus.cmd_imm;
        ok       = (depth_q != DMAX);
        inc      = 1'b1;
      end
      OP_POP: begin
        cmd_mode = `STACK_MODE_POP;
        ok       = (depth_q != '0);
        dec      = 1'b1;
      end
      OP_DUP: begin
        cmd_mode = `STACK_MODE_PUSH;
        cmd_d    = bus.top;
        ok       = (depth_q != '0) && (depth_q != DMAX);
        inc      = 1'b1;
      end
      OP_SWAP: begin
        cmd_mode = `STACK_MODE_SWAP;
        ok       = (depth_q >= DW'(2));
      end
      OP_ADD: begin
        cmd_mode = `STACK_MODE_ROLL2;
        cmd_d    = bus.second + bus.top;
        ok       = (depth_q >= DW'(2));
        dec      = 1'b1;
      end
      OP_SUB: begin
        cmd_mode = `STACK_MODE_ROLL2;
        cmd_d    = bus.second - bus.top;
        ok       = (depth_q >= DW'(2));
        dec      = 1'b1;
      end
      default: begin
        cmd_mode = `STACK_MODE_RESET;
        clr      = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    d_d     = d_q;
    depth_d = depth_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          if (CHECK && !ok) begin
            // Rejected commands still occupy an issue slot, but the slices see no-op.
            mode_d = `STACK_MODE_IDLE;
            d_d    = '0;
            err_d  = 1'b1;
          end else begin
            mode_d = cmd_mode;
            d_d    = cmd_d;
            if (clr) begin
              depth_d = '0;
              err_d   = 1'b0;
            end else if (inc && depth_q != DMAX) begin
              depth_d = depth_q + 1'b1;
            end else if (dec && depth_q != '0) begin
              depth_d = depth_q - 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset lands in ISSUE with a RESET mode so the slices get one clear cycle after release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_ISSUE;
      mode_q  <= `STACK_MODE_RESET;
      d_q     <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      d_q     <= d_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.mode      = (state_q == S_ISSUE) ? mode_q : `STACK_MODE_IDLE;
  assign bus.d         = (state_q == S_ISSUE) ? d_q : '0;
  assign bus.depth     = depth_q;
  assign bus.empty     = (depth_q == '0);
  assign bus.full      = (depth_q == DMAX);
  assign bus.err       = CHECK ? err_q : 1'b0;
endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - scoreboard bench for stack_controller driving a behavioural slice array
`ifndef STACK_MODE_IDLE
`define STACK_MODE_IDLE  3'd0
`define STACK_MODE_PUSH  3'd1
`define STACK_MODE_POP   3'd2
`define STACK_MODE_SWAP  3'd3
`define STACK_MODE_ROLL2 3'd4
`define STACK_MODE_RESET 3'd7
`endif

module tb_stack_controller;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int DW = $clog2(DEPTH + 1);
`ifdef STACK_CONTROLLER_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [DEPTH-1:0][WIDTH-1:0] stk_t;
  typedef struct {
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [DW-1:0]    depth;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_controller_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  stack_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  stk_t slices;
  stk_t ref_stk;
  int   ref_depth;
  logic ref_err;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   transfers = 0;

  function automatic stk_t apply_mode(input stk_t s, input logic [2:0] m, input logic [WIDTH-1:0] dv);
    stk_t r = s;
    case (m)
      `STACK_MODE_PUSH: begin
        for (int i = DEPTH - 1; i > 0; i--) r[i] = s[i-1];
        r[0] = dv;
      end
      `STACK_MODE_POP: begin
        for (int i = 0; i < DEPTH - 1; i++) r[i] = s[i+1];
        r[DEPTH-1] = '0;
      end
      `STACK_MODE_SWAP: begin
        r[0] = s[1];
        r[1] = s[0];
      end
      `STACK_MODE_ROLL2: begin
        r[0] = dv;
        for (int i = 1; i < DEPTH - 1; i++) r[i] = s[i+1];
        r[DEPTH-1] = '0;
      end
      `STACK_MODE_RESET: r = '0;
      default: ;
    endcase
    return r;
  endfunction

  assign bus.top    = slices[0];
  assign bus.second = slices[1];
  always @(posedge clk) slices <= apply_mode(slices, bus.mode, bus.d);

  // Scoreboard consumer: every transfer pops the prediction made when it was driven.
  logic acc;
  always @(posedge clk) begin
    acc = rst_n && bus.cmd_valid && bus.cmd_ready;
    #1;
    if (acc) begin
      transfers++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_transfer: no prediction queued at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.mode !== e.mode) begin
          miscompares++;
          $display("FAIL issue_mode: got %0d want %0d at %0t", bus.mode, e.mode, $time);
        end
        vectors++;
        if (bus.d !== e.d) begin
          miscompares++;
          $display("FAIL issue_d: got %0d want %0d at %0t", bus.d, e.d, $time);
        end
        vectors++;
        if (bus.depth !== e.depth) begin
          miscompares++;
          $display("FAIL issue_depth: got %0d want %0d at %0t", bus.depth, e.depth, $time);
        end
        vectors++;
        if (bus.err !== e.err) begin
          miscompares++;
          $display("FAIL issue_err: got %0b want %0b at %0t", bus.err, e.err, $time);
        end
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL issue_ready: got %0b want 0 at %0t", bus.cmd_ready, $time);
        end
        vectors++;
        if (bus.empty !== (e.depth == 0) || bus.full !== (e.depth == DW'(DEPTH))) begin
          miscompares++;
          $display("FAIL issue_flags: got empty=%0b full=%0b for depth %0d at %0t", bus.empty, bus.full, e.depth, $time);
        end
      end
    end
  end

  task automatic predict(input logic [2:0] op, input logic [WIDTH-1:0] imm);
    exp_t e;
    logic ok = 1'b1;
    logic [2:0] m;
    logic [WIDTH-1:0] dv = '0;
    logic [WIDTH-1:0] t = ref_stk[0];
    logic [WIDTH-1:0] s = ref_stk[1];
    int nd = ref_depth;
    case (op)
      3'd0: m = `STACK_MODE_IDLE;
      3'd1: begin m = `STACK_MODE_PUSH; dv = imm; ok = ref_depth < DEPTH; nd = ref_depth + 1; end
      3'd2: begin m = `STACK_MODE_POP; ok = ref_depth >= 1; nd = ref_depth - 1; end
      3'd3: begin m = `STACK_MODE_PUSH; dv = t; ok = ref_depth >= 1 && ref_depth < DEPTH; nd = ref_depth + 1; end
      3'd4: begin m = `STACK_MODE_SWAP; ok = ref_depth >= 2; end
      3'd5: begin m = `STACK_MODE_ROLL2; dv = s + t; ok = ref_depth >= 2; nd = ref_depth - 1; end
      3'd6: begin m = `STACK_MODE_ROLL2; dv = s - t; ok = ref_depth >= 2; nd = ref_depth - 1; end
      default: begin m = `STACK_MODE_RESET; nd = 0; end
    endcase
    if (CHK && !ok) begin
      m = `STACK_MODE_IDLE;
      dv = '0;
      nd = ref_depth;
      ref_err = 1'b1;
    end else begin
      if (nd > DEPTH) nd = DEPTH;
      if (nd < 0) nd = 0;
      if (op == 3'd7) ref_err = 1'b0;
    end
    ref_depth = nd;
    ref_stk = apply_mode(ref_stk, m, dv);
    e.mode = m;
    e.d = dv;
    e.depth = DW'(nd);
    e.err = ref_err;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [WIDTH-1:0] imm);
    int n = 0;
    exp_t dropped;
    predict(op, imm);
    @(negedge clk);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout: cmd_ready=%0b after %0d cycles", bus.cmd_ready, n);
      dropped = sb.pop_back();
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_imm = imm;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'($urandom);
    bus.cmd_imm = WIDTH'($urandom);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.cmd_imm = '0;
    rst_n = 1'b0;
    ref_stk = '0;
    ref_depth = 0;
    ref_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.mode !== `STACK_MODE_RESET || bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mode_ready: got mode=%0d ready=%0b want mode=%0d ready=0", bus.mode, bus.cmd_ready, `STACK_MODE_RESET);
    end
    vectors++;
    if (bus.depth !== '0 || bus.err !== 1'b0 || bus.d !== '0 || bus.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got depth=%0d err=%0b d=%0d empty=%0b want 0 0 0 1", bus.depth, bus.err, bus.d, bus.empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (bus.mode !== `STACK_MODE_RESET || bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_cycle: got mode=%0d ready=%0b want mode=%0d ready=0", bus.mode, bus.cmd_ready, `STACK_MODE_RESET);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.mode !== `STACK_MODE_IDLE || bus.top !== '0) begin
      miscompares++;
      $display("FAIL after_release: got ready=%0b mode=%0d top=%0d want 1 %0d 0", bus.cmd_ready, bus.mode, bus.top, `STACK_MODE_IDLE);
    end
  endtask

  task automatic test_push();
    send_cmd(3'd1, 4'd3);
    send_cmd(3'd1, 4'd5);
    vectors++;
    if (bus.depth !== DW'(2) || bus.top !== 4'd5 || bus.second !== 4'd3 || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_result: got depth=%0d top=%0d second=%0d ready=%0b want 2 5 3 1", bus.depth, bus.top, bus.second, bus.cmd_ready);
    end
  endtask

  task automatic test_alu();
    send_cmd(3'd5, 4'd0);
    vectors++;
    if (bus.depth !== DW'(1) || bus.top !== 4'd8) begin
      miscompares++;
      $display("FAIL add_result: got depth=%0d top=%0d want 1 8", bus.depth, bus.top);
    end
    send_cmd(3'd7, 4'd0);
    send_cmd(3'd1, 4'd9);
    send_cmd(3'd1, 4'd2);
    send_cmd(3'd6, 4'd0);
    vectors++;
    if (bus.top !== 4'd7 || bus.depth !== DW'(1)) begin
      miscompares++;
      $display("FAIL sub_9_minus_2: got top=%0d depth=%0d want 7 1", bus.top, bus.depth);
    end
    send_cmd(3'd7, 4'd0);
    send_cmd(3'd1, 4'd2);
    send_cmd(3'd1, 4'd9);
    send_cmd(3'd6, 4'd0);
    vectors++;
    if (bus.top !== 4'd9) begin
      miscompares++;
      $display("FAIL sub_wrap: got top=%0d want 9", bus.top);
    end
  endtask

  task automatic test_bounds();
    send_cmd(3'd7, 4'd0);
    send_cmd(3'd1, 4'd4);
    send_cmd(3'd4, 4'd0);
    vectors++;
    if (bus.err !== CHK || bus.depth !== DW'(1)) begin
      miscompares++;
      $display("FAIL swap_underflow: got err=%0b depth=%0d want %0b 1", bus.err, bus.depth, CHK);
    end
    send_cmd(3'd2, 4'd0);
    vectors++;
    if (bus.depth !== '0 || bus.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL pop_last: got depth=%0d empty=%0b want 0 1", bus.depth, bus.empty);
    end
    send_cmd(3'd2, 4'd0);
    vectors++;
    if (bus.depth !== '0 || bus.err !== CHK) begin
      miscompares++;
      $display("FAIL pop_empty: got depth=%0d err=%0b want 0 %0b", bus.depth, bus.err, CHK);
    end
  endtask

  task automatic test_full();
    send_cmd(3'd7, 4'd0);
    for (int i = 0; i < DEPTH; i++) send_cmd(3'd1, WIDTH'(i + 1));
    vectors++;
    if (bus.full !== 1'b1 || bus.depth !== DW'(DEPTH)) begin
      miscompares++;
      $display("FAIL fill: got full=%0b depth=%0d want 1 %0d", bus.full, bus.depth, DEPTH);
    end
    send_cmd(3'd1, 4'd15);
    vectors++;
    if (bus.depth !== DW'(DEPTH) || bus.err !== CHK || bus.top !== (CHK ? 4'd8 : 4'd15)) begin
      miscompares++;
      $display("FAIL overflow: got depth=%0d err=%0b top=%0d want %0d %0b %0d", bus.depth, bus.err, bus.top, DEPTH, CHK, CHK ? 8 : 15);
    end
    send_cmd(3'd7, 4'd0);
    vectors++;
    if (bus.depth !== '0 || bus.err !== 1'b0 || bus.top !== '0 || bus.second !== '0) begin
      miscompares++;
      $display("FAIL clear: got depth=%0d err=%0b top=%0d second=%0d want 0 0 0 0", bus.depth, bus.err, bus.top, bus.second);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    send_cmd(3'd7, 4'd0);
    send_cmd(3'd1, 4'd6);
    predict(3'd3, 4'd0);
    predict(3'd3, 4'd0);
    t0 = transfers;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd3;
    bus.cmd_imm = 4'd11;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    vectors++;
    if (transfers - t0 !== 2 || sb.size() !== 0) begin
      miscompares++;
      $display("FAIL dup_transfers: got %0d transfers (%0d pending) want 2 (0)", transfers - t0, sb.size());
    end
    vectors++;
    if (bus.depth !== DW'(3) || slices[0] !== 4'd6 || slices[1] !== 4'd6 || slices[2] !== 4'd6 || slices[3] !== 4'd0) begin
      miscompares++;
      $display("FAIL dup_contents: got depth=%0d s0..3=%0d %0d %0d %0d want 3 6 6 6 0", bus.depth, slices[0], slices[1], slices[2], slices[3]);
    end
  endtask

  task automatic test_saturate();
    int peak = 0;
    int wrapped = 0;
    int prev;
    send_cmd(3'd7, 4'd0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      prev = int'(bus.depth);
      send_cmd(3'd1, WIDTH'(i));
      if (int'(bus.depth) > peak) peak = int'(bus.depth);
      if (int'(bus.depth) < prev) wrapped++;
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      prev = int'(bus.depth);
      send_cmd(3'd2, 4'd0);
      if (int'(bus.depth) > prev) wrapped++;
    end
    vectors++;
    if (peak !== DEPTH || wrapped !== 0 || bus.depth !== '0) begin
      miscompares++;
      $display("FAIL saturate: got peak=%0d wraps=%0d final=%0d want %0d 0 0", peak, wrapped, bus.depth, DEPTH);
    end
    vectors++;
    if (bus.err !== CHK || bus.top !== '0) begin
      miscompares++;
      $display("FAIL saturate_err: got err=%0b top=%0d want %0b 0", bus.err, bus.top, CHK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_push();
    test_alu();
    test_bounds();
    test_full();
    test_back_to_back();
    test_saturate();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL leftover_predictions: got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
